// File: rtl/fcw_sweep_if.sv
// AXI-Stream phase channel between the sweep generator and the DDS compiler phase input.
// Carries valid/ready handshake and the accumulated phase word.
interface fcw_sweep_if #(
    parameter int unsigned PHASE_W = 32
);
    logic               tvalid;
    logic               tready;
    logic [PHASE_W-1:0] tdata;

    modport master (
        output tvalid,
        output tdata,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        output tready
    );
endinterface

// File: rtl/fcw_sweep_gen.sv
// Stepped frequency-sweep generator (single, sawtooth, triangle) with phase accumulation.
// Streams phase beats to a DDS compiler; fcw_out is the FCW sideband of the current beat.
module fcw_sweep_gen #(
    parameter int unsigned FCW_W   = 32,
    parameter int unsigned PHASE_W = 32,
    parameter int unsigned DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [1:0]         cfg_mode,
    input  logic [FCW_W-1:0]   cfg_fcw_start,
    input  logic [FCW_W-1:0]   cfg_fcw_stop,
    input  logic [FCW_W-1:0]   cfg_fcw_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [PHASE_W-1:0] cfg_phase_init,
    fcw_sweep_if.master        m_axis_phase,
    output logic [FCW_W-1:0]   fcw_out,
    output logic               busy,
    output logic               sweep_done,
    output logic               period_pulse
);

    typedef enum logic [1:0] {
        StIdle,
        StRunUp,
        StRunDown
    } state_e;

    localparam logic [1:0] ModeSaw = 2'd1;
    localparam logic [1:0] ModeTri = 2'd2;

    state_e             state_q, state_d;
    logic [PHASE_W-1:0] tdata_q, tdata_d;
    logic [FCW_W-1:0]   fcw_q, fcw_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic               sweep_done_q, sweep_done_d;
    logic               period_pulse_q, period_pulse_d;

    logic [1:0]         mode_q, mode_d;
    logic [FCW_W-1:0]   start_q, start_d;
    logic [FCW_W-1:0]   stop_q, stop_d;
    logic [FCW_W-1:0]   step_q, step_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;

    logic               running;
    logic               beat;
    logic               dwell_last;
    logic [FCW_W:0]     up_sum;
    logic [FCW_W-1:0]   up_next;
    logic [FCW_W-1:0]   down_gap;
    logic [FCW_W-1:0]   down_next;

    assign running    = (state_q != StIdle);
    assign beat       = running & m_axis_phase.tready;
    assign dwell_last = (dwell_cnt_q == dwell_q - DWELL_W'(1));

    // Up step in FCW_W+1 bits so a large step cannot wrap past stop.
    assign up_sum  = {1'b0, fcw_q} + {1'b0, step_q};
    assign up_next = (up_sum > {1'b0, stop_q}) ? stop_q : up_sum[FCW_W-1:0];

    // fcw_q >= start_q holds in every run state, so the gap never borrows.
    assign down_gap  = fcw_q - start_q;
    assign down_next = (step_q > down_gap) ? start_q : (fcw_q - step_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            tdata_q        <= '0;
            fcw_q          <= '0;
            dwell_cnt_q    <= '0;
            sweep_done_q   <= 1'b0;
            period_pulse_q <= 1'b0;
            mode_q         <= '0;
            start_q        <= '0;
            stop_q         <= '0;
            step_q         <= '0;
            dwell_q        <= '0;
        end else begin
            state_q        <= state_d;
            tdata_q        <= tdata_d;
            fcw_q          <= fcw_d;
            dwell_cnt_q    <= dwell_cnt_d;
            sweep_done_q   <= sweep_done_d;
            period_pulse_q <= period_pulse_d;
            mode_q         <= mode_d;
            start_q        <= start_d;
            stop_q         <= stop_d;
            step_q         <= step_d;
            dwell_q        <= dwell_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        tdata_d        = tdata_q;
        fcw_d          = fcw_q;
        dwell_cnt_d    = dwell_cnt_q;
        sweep_done_d   = 1'b0;
        period_pulse_d = 1'b0;
        mode_d         = mode_q;
        start_d        = start_q;
        stop_d         = stop_q;
        step_d         = step_q;
        dwell_d        = dwell_q;

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    mode_d      = cfg_mode;
                    start_d     = cfg_fcw_start;
                    stop_d      = (cfg_fcw_start > cfg_fcw_stop) ? cfg_fcw_start : cfg_fcw_stop;
                    step_d      = cfg_fcw_step;
                    dwell_d     = (cfg_dwell == '0) ? DWELL_W'(1) : cfg_dwell;
                    state_d     = StRunUp;
                    tdata_d     = cfg_phase_init;
                    fcw_d       = cfg_fcw_start;
                    dwell_cnt_d = '0;
                end
            end

            StRunUp: begin
                if (abort) begin
                    state_d     = StIdle;
                    dwell_cnt_d = '0;
                end else if (beat) begin
                    tdata_d = tdata_q + PHASE_W'(fcw_q);
                    if (!dwell_last) begin
                        dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
                    end else begin
                        dwell_cnt_d = '0;
                        if (fcw_q != stop_q) begin
                            fcw_d = up_next;
                        end else if (mode_q == ModeSaw) begin
                            fcw_d          = start_q;
                            period_pulse_d = 1'b1;
                        end else if (mode_q == ModeTri) begin
                            // A degenerate triangle has no down leg; every dwell is a period.
                            if (start_q == stop_q) begin
                                fcw_d          = start_q;
                                period_pulse_d = 1'b1;
                            end else begin
                                state_d = StRunDown;
                                fcw_d   = down_next;
                            end
                        end else begin
                            state_d      = StIdle;
                            sweep_done_d = 1'b1;
                        end
                    end
                end
            end

            StRunDown: begin
                if (abort) begin
                    state_d     = StIdle;
                    dwell_cnt_d = '0;
                end else if (beat) begin
                    tdata_d = tdata_q + PHASE_W'(fcw_q);
                    if (!dwell_last) begin
                        dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
                    end else begin
                        dwell_cnt_d = '0;
                        if (fcw_q != start_q) begin
                            fcw_d = down_next;
                        end else begin
                            state_d        = StRunUp;
                            fcw_d          = up_next;
                            period_pulse_d = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign m_axis_phase.tvalid = running;
    assign m_axis_phase.tdata  = tdata_q;
    assign fcw_out             = fcw_q;
    assign busy                = running;
    assign sweep_done          = sweep_done_q;
    assign period_pulse        = period_pulse_q;

    // A stalled beat must not change until the consumer takes it.
    hold_under_backpressure: assert property (
        @(posedge clk) disable iff (!rst_n)
        (m_axis_phase.tvalid && !m_axis_phase.tready && !abort)
            |=> (m_axis_phase.tvalid && $stable(m_axis_phase.tdata) && $stable(fcw_out))
    );

    done_only_when_idle: assert property (
        @(posedge clk) disable iff (!rst_n)
        sweep_done |-> !busy
    );

endmodule

// File: doc/fcw_sweep_gen.md
Name: fcw_sweep_gen

Overview:
Parametrised successor to the fixed-FCW DDS front end. Generates a stepped frequency sweep (single, sawtooth or triangle) and accumulates phase. Emits an AXI-Stream phase stream that directly drives the DDS compiler phase input (phase-streaming mode). Each phase beat carries its FCW as sideband.

Parameters:
FCW_W, 32, width of FCW, step and sweep limits
PHASE_W, 32, phase accumulator width, modulo 2^PHASE_W
DWELL_W, 16, width of dwell counter and cfg_dwell

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; latch cfg_* and begin sweep (honoured only in IDLE)
abort  in  1  pulse; terminate sweep
cfg_mode  in  2  0=single, 1=sawtooth, 2=triangle, 3=reserved (treated as single)
cfg_fcw_start  in  FCW_W  first/lower FCW
cfg_fcw_stop  in  FCW_W  upper FCW limit
cfg_fcw_step  in  FCW_W  FCW increment per dwell
cfg_dwell  in  DWELL_W  beats per FCW value; 0 treated as 1
cfg_phase_init  in  PHASE_W  phase of first beat
m_axis_phase_tvalid  out  1  phase beat valid
m_axis_phase_tready  in  1  downstream ready
m_axis_phase_tdata  out  PHASE_W  accumulated phase
fcw_out  out  FCW_W  FCW in effect for current beat
busy  out  1  high in RUN_UP/RUN_DOWN
sweep_done  out  1  one-cycle pulse at single-mode completion
period_pulse  out  1  one-cycle pulse when saw/tri sweep returns to start

Behaviour:
- Reset (async assert, sync deassert via clk): state=IDLE; tvalid, busy, sweep_done, period_pulse=0; tdata=0; fcw_out=0; dwell counter=0; latched config=0.
- All outputs registered; no combinational path from tready to tvalid.
- States: IDLE, RUN_UP, RUN_DOWN.
- IDLE + start at edge N: latch config. If cfg_fcw_start > cfg_fcw_stop, latched stop = start.
  - At N+1: state RUN_UP, tvalid=1, tdata=cfg_phase_init, fcw_out=cfg_fcw_start, busy=1.
- Beat accepted = tvalid & tready. While tvalid & !tready, tdata/fcw_out held stable and the dwell counter is frozen.
- On each accepted beat: tdata <= tdata + fcw_out (mod 2^PHASE_W); dwell counter increments.
- When the accepted beat completes the dwell count (counter reaches max(cfg_dwell,1)), the counter clears and the next FCW is chosen:
  - RUN_UP, fcw_out < stop: next = min(fcw_out + step, stop), computed in FCW_W+1 bits (no wrap).
  - RUN_UP, fcw_out == stop:
    - single: go to IDLE, tvalid=0, busy=0, sweep_done=1 for one cycle.
    - sawtooth: next = start, period_pulse=1.
    - triangle: go to RUN_DOWN, next = max(fcw_out - step, start) with borrow-safe compare.
  - RUN_DOWN, fcw_out > start: next = max(fcw_out - step, start).
  - RUN_DOWN, fcw_out == start: go to RUN_UP, next = min(start + step, stop), period_pulse=1.
- Each endpoint dwells exactly once per traversal. The phase stays continuous across FCW changes; there is no phase reset on wrap.
- step == 0: FCW stays at start forever in every mode, until abort.
- start == stop: single mode ends after one dwell; sawtooth/triangle hold that FCW and pulse period_pulse every dwell.
- abort (any state): next edge goes to IDLE with tvalid=0 and busy=0. The beat shown in that cycle is dropped even if accepted. No sweep_done.
- abort and start in the same cycle: abort wins.
- start while busy: ignored; config is not re-latched.
- rst_n low mid-sweep: immediate reset values, independent of clk.

Test Plan:
- Single sweep: start=100, stop=130, step=10, dwell=2, phase_init=0, tready=1 -> fcw_out 100,100,110,110,120,120,130,130; tdata 0,100,200,310,420,540,660,790; tvalid low on the next cycle with sweep_done=1 for exactly one cycle.
- Clamp: start=0, stop=25, step=10, dwell=1, single -> fcw_out 0,10,20,25, then done; no 30 ever appears.
- Triangle: start=0, stop=20, step=10, dwell=1 -> fcw_out 0,10,20,10,0,10,20,...; period_pulse on each transition out of fcw=0 after the first period; busy stays high.
- Backpressure: single sweep as in the first scenario, drop tready for 3 cycles on the 3rd beat -> tdata=200 and fcw_out=110 held for 3 cycles; the subsequent sequence is identical to the first scenario.
- Phase wrap: phase_init=0xFFFFFFF0, start=stop=0x20, sawtooth, dwell=4 -> tdata 0xFFFFFFF0, 0x00000010, 0x00000030, 0x00000050; period_pulse every 4 beats.
- Abort/reset: abort on the 4th beat of the first scenario -> next cycle tvalid=0, busy=0, sweep_done=0, and a following start is accepted. Assert rst_n low mid-sweep between clock edges -> all outputs 0 immediately.
